// File: rtl/router_pkt_src_if.sv
// Host/router-side bundle of router_pkt_src: payload write port, request handshake, router byte stream.
// The err_inj input exists only when PKT_SRC_ERRINJ_EN is defined.
interface router_pkt_src_if;
`ifdef PKT_SRC_ERRINJ_EN
  logic       err_inj;
`endif
  logic       pld_wr_en;
  logic [7:0] pld_wr_data;
  logic       pld_full;
  logic [6:0] pld_count;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_ready;
  logic       req_err;
  logic       busy;
  logic [7:0] data_in;
  logic       pkt_valid;
  logic       pkt_done;

  modport master (
`ifdef PKT_SRC_ERRINJ_EN
    output err_inj,
`endif
    output pld_wr_en, pld_wr_data, req_valid, req_addr, req_len, busy,
    input  pld_full, pld_count, req_ready, req_err, data_in, pkt_valid, pkt_done
  );

  modport slave (
`ifdef PKT_SRC_ERRINJ_EN
    input  err_inj,
`endif
    input  pld_wr_en, pld_wr_data, req_valid, req_addr, req_len, busy,
    output pld_full, pld_count, req_ready, req_err, data_in, pkt_valid, pkt_done
  );
endinterface

// File: rtl/router_pkt_src.sv
// Packet source feeding the 1x3 router: buffers payload, then emits header, payload and XOR parity
// back to back. Optional parity error injection is enabled by defining PKT_SRC_ERRINJ_EN.
module router_pkt_src #(
  parameter int PLD_DEPTH  = 64,
  parameter int GAP_CYCLES = 3
) (
  input  logic           clk,
  input  logic           resetn,
  router_pkt_src_if.slave bus
);

  localparam int AW = $clog2(PLD_DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, HDR, PLD, PAR, GAP} state_t;

  state_t        state, state_nxt;

  logic [7:0]    mem [PLD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [6:0]    count, count_nxt;
  logic          full, push, pop;

  logic [7:0]    data_q, data_nxt;
  logic          pkt_valid_q, pkt_valid_nxt;
  logic          pkt_done_q, pkt_done_nxt;
  logic          req_err_q, req_err_nxt;
  logic [5:0]    rem, rem_nxt;
  logic [7:0]    parity, parity_nxt;
  logic [GW-1:0] gap_left, gap_nxt;

  logic          illegal, req_ready, take, accept, inv_par;

  assign full      = (count == 7'(PLD_DEPTH));
  assign push      = bus.pld_wr_en & ~full;
  assign illegal   = (bus.req_len == 6'd0) | (bus.req_addr == 2'b11);
  assign req_ready = (state == IDLE) & (illegal | ({1'b0, bus.req_len} <= count));
  assign take      = bus.req_valid & req_ready;
  assign accept    = ~bus.busy;

`ifdef PKT_SRC_ERRINJ_EN
  logic err_flag;

  always_ff @(posedge clk) begin
    if (state == IDLE && take && !illegal)
      err_flag <= bus.err_inj;
  end

  assign inv_par = err_flag;
`else
  assign inv_par = 1'b0;
`endif

  // Payload buffer storage; pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.pld_wr_data;
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 7'd1;
      2'b01:   count_nxt = count - 7'd1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    data_nxt      = data_q;
    pkt_valid_nxt = pkt_valid_q;
    pkt_done_nxt  = 1'b0;
    req_err_nxt   = 1'b0;
    pop           = 1'b0;
    rem_nxt       = rem;
    parity_nxt    = parity;
    gap_nxt       = gap_left;

    case (state)
      IDLE: begin
        if (take) begin
          if (illegal) begin
            req_err_nxt = 1'b1;
          end else begin
            rem_nxt       = bus.req_len;
            parity_nxt    = 8'h00;
            data_nxt      = {bus.req_len, bus.req_addr};
            pkt_valid_nxt = 1'b1;
            state_nxt     = HDR;
          end
        end
      end

      HDR: begin
        if (accept) begin
          parity_nxt = parity ^ data_q;
          pop        = 1'b1;
          data_nxt   = mem[rd_ptr];
          state_nxt  = PLD;
        end
      end

      // Next byte is prepared in the same cycle the current one is consumed: no bubbles
      PLD: begin
        if (accept) begin
          parity_nxt = parity ^ data_q;
          rem_nxt    = rem - 6'd1;
          if (rem == 6'd1) begin
            data_nxt      = (parity ^ data_q) ^ {8{inv_par}};
            pkt_valid_nxt = 1'b0;
            state_nxt     = PAR;
          end else begin
            pop      = 1'b1;
            data_nxt = mem[rd_ptr];
          end
        end
      end

      PAR: begin
        if (accept) begin
          pkt_done_nxt = 1'b1;
          data_nxt     = 8'h00;
          gap_nxt      = GW'(GAP_CYCLES);
          state_nxt    = GAP;
        end
      end

      // Gap counts down regardless of busy; leaving it waits for busy to drop
      GAP: begin
        if (gap_left > GW'(1))
          gap_nxt = gap_left - GW'(1);
        else if (accept)
          state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= 7'd0;
      data_q      <= 8'h00;
      pkt_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      req_err_q   <= 1'b0;
      rem         <= 6'd0;
      gap_left    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      data_q      <= data_nxt;
      pkt_valid_q <= pkt_valid_nxt;
      pkt_done_q  <= pkt_done_nxt;
      req_err_q   <= req_err_nxt;
      rem         <= rem_nxt;
      gap_left    <= gap_nxt;
    end
  end

  always_ff @(posedge clk) begin
    parity <= parity_nxt;
  end

  assign bus.pld_full  = full;
  assign bus.pld_count = count;
  assign bus.req_ready = req_ready;
  assign bus.req_err   = req_err_q;
  assign bus.data_in   = data_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src: reset, basic packet, stall, insufficient payload,
// illegal requests, buffer full / 63-byte burst, and reset mid-packet.
module tb_router_pkt_src;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  router_pkt_src_if bus();

  router_pkt_src #(.PLD_DEPTH(64), .GAP_CYCLES(3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.pld_wr_en   = 1'b1;
    bus.pld_wr_data = b;
    tick();
    bus.pld_wr_en   = 1'b0;
  endtask

  task automatic exp_byte(input string tag, input logic [7:0] d, input logic v);
    chk({tag, "_data"}, {24'd0, bus.data_in}, {24'd0, d});
    chk({tag, "_vld"}, {31'd0, bus.pkt_valid}, {31'd0, v});
  endtask

  // Called in the cycle pkt_done is high; sees three gap cycles, then IDLE again
  task automatic gap_check(input string tag);
    logic [1:0] a_save;
    a_save = bus.req_addr;
    bus.req_addr = 2'b11;
    #1;
    chk({tag, "_gap0"}, {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk({tag, "_gap1"}, {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk({tag, "_gap2"}, {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk({tag, "_idle"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_addr = a_save;
    #1;
  endtask

  task automatic request(input logic [1:0] a, input logic [5:0] l);
    bus.req_addr  = a;
    bus.req_len   = l;
    bus.req_valid = 1'b1;
    #1;
    chk("req_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] par;
    logic [7:0] b;

    resetn          = 1'b1;
    bus.pld_wr_en   = 1'b0;
    bus.pld_wr_data = 8'h00;
    bus.req_valid   = 1'b0;
    bus.req_addr    = 2'd0;
    bus.req_len     = 6'd0;
    bus.busy        = 1'b0;
`ifdef PKT_SRC_ERRINJ_EN
    bus.err_inj     = 1'b0;
`endif

    tick();
    tick();
    chk("rst_data", {24'd0, bus.data_in}, 32'd0);
    chk("rst_vld", {31'd0, bus.pkt_valid}, 32'd0);
    chk("rst_count", {25'd0, bus.pld_count}, 32'd0);
    chk("rst_full", {31'd0, bus.pld_full}, 32'd0);
    chk("rst_done", {31'd0, bus.pkt_done}, 32'd0);
    chk("rst_err", {31'd0, bus.req_err}, 32'd0);
    bus.req_len  = 6'd3;
    bus.req_addr = 2'd1;
    #1;
    chk("rst_ready_legal", {31'd0, bus.req_ready}, 32'd0);
    bus.req_addr = 2'd3;
    #1;
    chk("rst_ready_illegal", {31'd0, bus.req_ready}, 32'd1);
    resetn = 1'b0;
    tick();

    // Basic packet: addr 1, len 3
    push(8'h11); push(8'h22); push(8'h33);
    chk("basic_count", {25'd0, bus.pld_count}, 32'd3);
    request(2'd1, 6'd3);
    exp_byte("basic_hdr", 8'h0D, 1'b1);
    tick(); exp_byte("basic_p0", 8'h11, 1'b1);
    chk("basic_count_pop", {25'd0, bus.pld_count}, 32'd2);
    tick(); exp_byte("basic_p1", 8'h22, 1'b1);
    tick(); exp_byte("basic_p2", 8'h33, 1'b1);
    tick(); exp_byte("basic_par", 8'h0D, 1'b0);
    chk("basic_done_early", {31'd0, bus.pkt_done}, 32'd0);
    tick();
    chk("basic_done", {31'd0, bus.pkt_done}, 32'd1);
    exp_byte("basic_after", 8'h00, 1'b0);
    gap_check("basic");
    chk("basic_done_pulse", {31'd0, bus.pkt_done}, 32'd0);

    // Stall: busy for 4 cycles while 22 presented
    push(8'h11); push(8'h22); push(8'h33);
    request(2'd1, 6'd3);
    exp_byte("stall_hdr", 8'h0D, 1'b1);
    tick(); exp_byte("stall_p0", 8'h11, 1'b1);
    tick(); exp_byte("stall_p1", 8'h22, 1'b1);
    bus.busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); exp_byte("stall_hold", 8'h22, 1'b1);
    end
    bus.busy = 1'b0;
    tick(); exp_byte("stall_p2", 8'h33, 1'b1);
    tick(); exp_byte("stall_par", 8'h0D, 1'b0);
    tick();
    chk("stall_done", {31'd0, bus.pkt_done}, 32'd1);
    gap_check("stall");

    // Insufficient payload, then third byte arrives
    push(8'h44); push(8'h55);
    bus.req_addr  = 2'd2;
    bus.req_len   = 6'd3;
    bus.req_valid = 1'b1;
    #1;
    chk("insuf_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("insuf_vld", {31'd0, bus.pkt_valid}, 32'd0);
    push(8'h66);
    chk("insuf_ready_now", {31'd0, bus.req_ready}, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    exp_byte("insuf_hdr", 8'h0E, 1'b1);
    tick(); exp_byte("insuf_p0", 8'h44, 1'b1);
    tick(); exp_byte("insuf_p1", 8'h55, 1'b1);
    tick(); exp_byte("insuf_p2", 8'h66, 1'b1);
    tick(); exp_byte("insuf_par", 8'h79, 1'b0);
    tick();
    chk("insuf_done", {31'd0, bus.pkt_done}, 32'd1);
    gap_check("insuf");

    // Illegal requests: addr 3, then len 0
    push(8'h77);
    request(2'd3, 6'd5);
    chk("ill_addr_err", {31'd0, bus.req_err}, 32'd1);
    chk("ill_addr_vld", {31'd0, bus.pkt_valid}, 32'd0);
    chk("ill_addr_count", {25'd0, bus.pld_count}, 32'd1);
    tick();
    chk("ill_addr_err_end", {31'd0, bus.req_err}, 32'd0);
    request(2'd0, 6'd0);
    chk("ill_len_err", {31'd0, bus.req_err}, 32'd1);
    chk("ill_len_vld", {31'd0, bus.pkt_valid}, 32'd0);
    chk("ill_len_count", {25'd0, bus.pld_count}, 32'd1);
    tick();
    chk("ill_len_err_end", {31'd0, bus.req_err}, 32'd0);
    chk("ill_len_vld2", {31'd0, bus.pkt_valid}, 32'd0);

    // Fill to 64, overflow push ignored
    for (int i = 1; i <= 63; i++) push(8'(i));
    chk("fill_full", {31'd0, bus.pld_full}, 32'd1);
    chk("fill_count", {25'd0, bus.pld_count}, 32'd64);
    push(8'hEE);
    chk("ovf_count", {25'd0, bus.pld_count}, 32'd64);
    chk("ovf_full", {31'd0, bus.pld_full}, 32'd1);

    // 63-byte packet: 65 consecutive cycles
    request(2'd0, 6'd63);
    exp_byte("long_hdr", 8'hFC, 1'b1);
    par = 8'hFC;
    for (int k = 0; k < 63; k++) begin
      b = (k == 0) ? 8'h77 : 8'(k);
      tick();
      exp_byte("long_pld", b, 1'b1);
      par = par ^ b;
    end
    tick(); exp_byte("long_par", par, 1'b0);
    tick();
    chk("long_done", {31'd0, bus.pkt_done}, 32'd1);
    chk("long_count", {25'd0, bus.pld_count}, 32'd1);
    gap_check("long");

    // Remaining byte is 0x3F, not the ignored 0xEE
    request(2'd1, 6'd1);
    exp_byte("last_hdr", 8'h05, 1'b1);
    tick(); exp_byte("last_p0", 8'h3F, 1'b1);
    tick(); exp_byte("last_par", 8'h3A, 1'b0);
    tick();
    chk("last_done", {31'd0, bus.pkt_done}, 32'd1);
    chk("last_count", {25'd0, bus.pld_count}, 32'd0);
    gap_check("last");

    // Reset in the middle of payload
    push(8'hAA); push(8'hBB); push(8'hCC);
    request(2'd2, 6'd3);
    exp_byte("mrst_hdr", 8'h0E, 1'b1);
    tick(); exp_byte("mrst_p0", 8'hAA, 1'b1);
    resetn = 1'b1;
    tick();
    exp_byte("mrst_cut", 8'h00, 1'b0);
    chk("mrst_count", {25'd0, bus.pld_count}, 32'd0);
    resetn = 1'b0;
    tick();
    chk("mrst_no_done", {31'd0, bus.pkt_done}, 32'd0);
    chk("mrst_vld", {31'd0, bus.pkt_valid}, 32'd0);
    bus.req_addr = 2'd1;
    bus.req_len  = 6'd1;
    #1;
    chk("mrst_ready", {31'd0, bus.req_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
